// File: rtl/mem_bus_ctrl.sv
// Memory access sequencer: latches MAB/MDB/RW/BW on req, drives a single-port memory with
// byte lanes and wait states, and aborts with vacant data on timeout. Optional: MEM_ALIGN_CHECK_EN.
module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [15:0] MAB_in,
    input  logic [15:0] MDB_in,
    input  logic        RW,
    input  logic        BW,
    output logic        mem_en,
    output logic [1:0]  mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] MDB_out,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic        r_a0;
    logic        r_rw;
    logic        r_bw;
    logic        r_mem_en;
    logic [1:0]  r_mem_we;
    logic [14:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_mdb_out;
    logic        r_err;

    logic        w_accept;
    logic        w_misalign;
    logic        w_ready_hit;
    logic        w_timeout;
    logic [1:0]  w_lanes;
    logic [15:0] w_wdata;
    logic [15:0] w_rd_sel;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = ~BW & MAB_in[0];
`else
    // Word accesses silently use the even word address.
    assign w_misalign = 1'b0;
`endif

    assign w_lanes  = BW ? (MAB_in[0] ? 2'b10 : 2'b01) : 2'b11;
    assign w_wdata  = BW ? {MDB_in[7:0], MDB_in[7:0]} : MDB_in;
    assign w_rd_sel = r_bw ? (r_a0 ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]})
                           : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready has priority over the timeout when both occur on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ready_hit = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_misalign ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    w_ready_hit = 1'b1;
                    w_state_nxt = S_DONE;
                end else if ((TIMEOUT_CNT != 8'd0) && (r_wait_cnt == TIMEOUT_CNT)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt  <= 8'd0;
            r_a0        <= 1'b0;
            r_rw        <= 1'b0;
            r_bw        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 2'b00;
            r_mem_addr  <= 15'd0;
            r_mem_wdata <= 16'd0;
            r_mdb_out   <= 16'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wait_cnt <= 8'd0;
                        if (w_misalign) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err       <= 1'b0;
                            r_a0        <= MAB_in[0];
                            r_rw        <= RW;
                            r_bw        <= BW;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= RW ? w_lanes : 2'b00;
                            r_mem_addr  <= MAB_in[15:1];
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_ready_hit) begin
                        r_mem_en <= 1'b0;
                        r_mem_we <= 2'b00;
                        r_err    <= 1'b0;
                        if (!r_rw) begin
                            r_mdb_out <= w_rd_sel;
                        end
                    end else if (w_timeout) begin
                        r_mem_en <= 1'b0;
                        r_mem_we <= 2'b00;
                        r_err    <= 1'b1;
                        if (!r_rw) begin
                            r_mdb_out <= r_bw ? 16'h00FF : 16'h3FFF;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_err <= 1'b0;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 2'b00;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign MDB_out   = r_mdb_out;
    assign busy      = (r_state == S_ACCESS) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err & (r_state == S_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl (TIMEOUT = 3): table of accesses plus hand sequences for reset and req-while-busy.
module tb_mem_bus_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [15:0] MAB_in;
    logic [15:0] MDB_in;
    logic        RW;
    logic        BW;
    logic        mem_en;
    logic [1:0]  mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] MDB_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    mem_bus_ctrl #(.TIMEOUT(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .MAB_in(MAB_in), .MDB_in(MDB_in),
        .RW(RW), .BW(BW), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .MDB_out(MDB_out), .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        bw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          waits;     // not-ready edges before mem_ready; 255 = never ready
        bit          pulse;     // toggle req while busy and in DONE
        logic        exp_en;
        logic [1:0]  exp_we;
        logic [14:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [15:0] exp_mdb;
        logic        exp_err;
        int          exp_k;     // edges after the req-sampling edge until done is seen
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic bw, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] rdata,
                                input int waits, input bit pulse, input logic exp_en,
                                input logic [1:0] exp_we, input logic [14:0] exp_addr,
                                input logic [15:0] exp_wdata, input logic [15:0] exp_mdb,
                                input logic exp_err, input int exp_k);
        vec_t v;
        v.rw = rw; v.bw = bw; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.waits = waits; v.pulse = pulse; v.exp_en = exp_en; v.exp_we = exp_we;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_mdb = exp_mdb;
        v.exp_err = exp_err; v.exp_k = exp_k;
        return v;
    endfunction

    // Called at a negedge with the block in IDLE; returns at a negedge with the block in IDLE.
    task automatic do_access(input vec_t v, input int idx);
        int k;
        req = 1'b1; MAB_in = v.addr; MDB_in = v.wdata; RW = v.rw; BW = v.bw;
        mem_rdata = v.rdata; mem_ready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        check($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'(v.exp_en));
        check($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.exp_we));
        if (v.exp_en) check($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.exp_addr));
        if (v.exp_en && v.rw) check($sformatf("v%0d mem_wdata", idx), 32'(mem_wdata), 32'(v.exp_wdata));
        k = 0;
        while (!done && k < 20) begin
            mem_ready = (k == v.waits);
            if (v.pulse) begin
                req = k[0];
                MAB_in = 16'hFFFE;
            end
            @(negedge clk);
            k++;
        end
        req = 1'b0;
        check($sformatf("v%0d latency", idx), 32'(k), 32'(v.exp_k));
        check($sformatf("v%0d done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d MDB_out", idx), 32'(MDB_out), 32'(v.exp_mdb));
        check($sformatf("v%0d mem_en_done", idx), 32'(mem_en), 32'd0);
        if (v.exp_en) check($sformatf("v%0d mem_addr_held", idx), 32'(mem_addr), 32'(v.exp_addr));
        mem_ready = 1'b0;
        if (v.pulse) begin
            req = 1'b1;
            MAB_in = 16'h0400;
        end
        @(negedge clk);
        req = 1'b0;
        check($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
        check($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d idle_state", idx), 32'(dbg_state), 32'd0);
        if (v.pulse) begin
            @(negedge clk);
            check($sformatf("v%0d req_in_done_ignored", idx), 32'(dbg_state), 32'd0);
            check($sformatf("v%0d no_strobe", idx), 32'(mem_en), 32'd0);
        end
    endtask

    initial begin
        //          rw    bw    addr      wdata     rdata    waits pulse en    we     addr      wdata     mdb       err   k
        vecs[0]  = mk(1'b0, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, 0,   0, 1'b1, 2'b00, 15'h0100, 16'h0000, 16'hBEEF, 1'b0, 1);
        vecs[1]  = mk(1'b1, 1'b1, 16'h0201, 16'h12A5, 16'h0000, 2,   0, 1'b1, 2'b10, 15'h0100, 16'hA5A5, 16'hBEEF, 1'b0, 3);
        vecs[2]  = mk(1'b0, 1'b1, 16'h0203, 16'h0000, 16'h7F01, 0,   0, 1'b1, 2'b00, 15'h0101, 16'h0000, 16'h007F, 1'b0, 1);
        vecs[3]  = mk(1'b0, 1'b1, 16'h0202, 16'h0000, 16'h7F01, 1,   0, 1'b1, 2'b00, 15'h0101, 16'h0000, 16'h0001, 1'b0, 2);
        vecs[4]  = mk(1'b1, 1'b0, 16'h0400, 16'hCAFE, 16'h0000, 0,   0, 1'b1, 2'b11, 15'h0200, 16'hCAFE, 16'h0001, 1'b0, 1);
        vecs[5]  = mk(1'b1, 1'b1, 16'h0300, 16'h005A, 16'h0000, 1,   0, 1'b1, 2'b01, 15'h0180, 16'h5A5A, 16'h0001, 1'b0, 2);
        vecs[6]  = mk(1'b0, 1'b0, 16'h0200, 16'h0000, 16'h9999, 255, 1, 1'b1, 2'b00, 15'h0100, 16'h0000, 16'h3FFF, 1'b1, 4);
        vecs[7]  = mk(1'b0, 1'b1, 16'h0301, 16'h0000, 16'h9999, 255, 0, 1'b1, 2'b00, 15'h0180, 16'h0000, 16'h00FF, 1'b1, 4);
        vecs[8]  = mk(1'b1, 1'b0, 16'h0100, 16'h1111, 16'h0000, 255, 0, 1'b1, 2'b11, 15'h0080, 16'h1111, 16'h00FF, 1'b1, 4);
        vecs[9]  = mk(1'b0, 1'b0, 16'h0206, 16'h0000, 16'h5555, 3,   0, 1'b1, 2'b00, 15'h0103, 16'h0000, 16'h5555, 1'b0, 4);
`ifdef MEM_ALIGN_CHECK_EN
        vecs[10] = mk(1'b0, 1'b0, 16'h0205, 16'h0000, 16'h1234, 0,   0, 1'b0, 2'b00, 15'h0000, 16'h0000, 16'h5555, 1'b1, 0);
`else
        vecs[10] = mk(1'b0, 1'b0, 16'h0205, 16'h0000, 16'h1234, 0,   0, 1'b1, 2'b00, 15'h0102, 16'h0000, 16'h1234, 1'b0, 1);
`endif

        rst_n = 1'b0; req = 1'b0; MAB_in = 16'h0; MDB_in = 16'h0; RW = 1'b0; BW = 1'b0;
        mem_rdata = 16'h0; mem_ready = 1'b0;
        #12;
        check("rst mem_en", 32'(mem_en), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst MDB_out", 32'(MDB_out), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted in the middle of a stalled word write.
        req = 1'b1; MAB_in = 16'h0200; MDB_in = 16'hABCD; RW = 1'b1; BW = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        check("midrst mem_en_before", 32'(mem_en), 32'd1);
        check("midrst mem_we_before", 32'(mem_we), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst mem_en", 32'(mem_en), 32'd0);
        check("midrst mem_we", 32'(mem_we), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst state", 32'(dbg_state), 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        check("midrst mem_en_held", 32'(mem_en), 32'd0);
        check("midrst mem_we_held", 32'(mem_we), 32'd0);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("midrst idle_after", 32'(dbg_state), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst mem_en_after", 32'(mem_en), 32'd0);

        for (int i = 0; i < 11; i++) begin
            do_access(vecs[i], i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
